// File: rtl/cv32e40p_tmr_fault_monitor.sv
// TMR voter fault monitor: persistence FSM, saturating counter, first-index capture and irq.
// Optional sticky per-voter mask is built when CV32E40P_TMR_FAULT_MASK_EN is defined.
module cv32e40p_tmr_fault_monitor #(
  parameter int N_VOTERS    = 32,
  parameter int CNT_W       = 16,
  parameter int PERSIST_THR = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_i,
  input  logic [N_VOTERS-1:0]         faulty_i,
  input  logic                        clear_i,
  input  logic                        irq_ack_i,
  output logic [1:0]                  state_o,
  output logic [CNT_W-1:0]            fault_cnt_o,
  output logic                        first_vld_o,
  output logic [$clog2(N_VOTERS)-1:0] first_idx_o,
  output logic                        irq_o,
  output logic [N_VOTERS-1:0]         fault_mask_o
);

  localparam int IDX_W = $clog2(N_VOTERS);
  localparam logic [7:0] THR = 8'(PERSIST_THR);
  localparam bit THR_ONE = (PERSIST_THR == 1);

  typedef enum logic [1:0] {
    S_OK    = 2'd0,
    S_TRANS = 2'd1,
    S_PERM  = 2'd2
  } state_t;

  state_t             state_q;
  logic [7:0]         persist_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               vld_q;
  logic [IDX_W-1:0]   idx_q;
  logic               irq_q;
  logic               irq_sent_q;
  logic               fault_any;
  logic [IDX_W-1:0]   low_idx;

  assign fault_any = en_i & (|faulty_i);

  // Priority encoder: lowest set faulty_i bit
  always_comb begin
    low_idx = '0;
    for (int i = N_VOTERS - 1; i >= 0; i--) begin
      if (faulty_i[i]) low_idx = IDX_W'(i);
    end
  end

  // FSM, counter, first-index capture and interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OK;
      persist_q  <= '0;
      cnt_q      <= '0;
      vld_q      <= 1'b0;
      idx_q      <= '0;
      irq_q      <= 1'b0;
      irq_sent_q <= 1'b0;
    end else if (clear_i) begin
      state_q    <= S_OK;
      persist_q  <= '0;
      cnt_q      <= '0;
      vld_q      <= 1'b0;
      idx_q      <= '0;
      irq_q      <= 1'b0;
      irq_sent_q <= 1'b0;
    end else begin
      if (fault_any && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (fault_any && !vld_q) begin
        vld_q <= 1'b1;
        idx_q <= low_idx;
      end
      unique case (state_q)
        S_OK: begin
          if (fault_any) begin
            if (THR_ONE) begin
              state_q <= S_PERM;
            end else begin
              state_q   <= S_TRANS;
              persist_q <= 8'd1;
            end
          end
        end
        S_TRANS: begin
          if (fault_any) begin
            if (persist_q + 8'd1 == THR) begin
              state_q <= S_PERM;
            end else begin
              persist_q <= persist_q + 8'd1;
            end
          end else begin
            state_q   <= S_OK;
            persist_q <= '0;
          end
        end
        S_PERM: begin
          state_q <= S_PERM;
        end
        default: begin
          state_q   <= S_OK;
          persist_q <= '0;
        end
      endcase
      // irq fires once per PERMANENT episode; ack only matters while high
      if (irq_q && irq_ack_i) begin
        irq_q <= 1'b0;
      end else if ((state_q == S_PERM) && !irq_sent_q) begin
        irq_q      <= 1'b1;
        irq_sent_q <= 1'b1;
      end
    end
  end

  assign state_o     = state_q;
  assign fault_cnt_o = cnt_q;
  assign first_vld_o = vld_q;
  assign first_idx_o = idx_q;
  assign irq_o       = irq_q;

`ifdef CV32E40P_TMR_FAULT_MASK_EN
  logic [N_VOTERS-1:0] mask_q;

  // Sticky per-voter mask of every voter seen faulty while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (clear_i) begin
      mask_q <= '0;
    end else if (en_i) begin
      mask_q <= mask_q | faulty_i;
    end
  end

  assign fault_mask_o = mask_q;
`else
  assign fault_mask_o = '0;
`endif

endmodule

// File: doc/cv32e40p_tmr_fault_monitor.md
CV32E40P_TMR_FAULT_MONITOR -- requirements
Module: cv32e40p_tmr_fault_monitor

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- N_VOTERS, 32, number of voter faulty flags monitored.
- CNT_W, 16, fault counter width.
- PERSIST_THR, 4, consecutive faulty cycles that declare a permanent fault; legal range 1..255.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- en_i, in, 1, monitoring enable; when low, faulty_i is ignored.
- faulty_i, in, N_VOTERS, per-voter disagreement flags from the TMR voters.
- clear_i, in, 1, one-cycle pulse that clears all monitor state.
- irq_ack_i, in, 1, acknowledge for irq_o.
- state_o, out, 2, FSM state: 0 OK, 1 TRANSIENT, 2 PERMANENT.
- fault_cnt_o, out, CNT_W, saturating count of faulty cycles.
- first_vld_o, out, 1, first_idx_o holds a captured index.
- first_idx_o, out, $clog2(N_VOTERS), lowest faulty voter index at the first fault.
- irq_o, out, 1, permanent-fault interrupt.
- fault_mask_o, out, N_VOTERS, sticky per-voter fault mask (see REQ-016).

Function
REQ-003 fault_any SHALL equal en_i AND (OR-reduction of faulty_i), evaluated every cycle.

REQ-004 FSM transitions from OK SHALL be:
- fault_any and PERSIST_THR==1 -> PERMANENT.
- fault_any and PERSIST_THR>1 -> TRANSIENT, with persist_cnt=1.
- otherwise stay in OK.

REQ-005 In TRANSIENT, transitions SHALL be:
- fault_any and persist_cnt+1==PERSIST_THR -> PERMANENT.
- fault_any otherwise -> stay in TRANSIENT and increment persist_cnt.
- !fault_any -> OK, with persist_cnt=0.

REQ-006 PERMANENT SHALL be left only via clear_i or reset; persist_cnt is frozen there.

REQ-007 fault_cnt_o SHALL increment by 1 on every cycle with fault_any, and saturate at 2^CNT_W-1 with no wrap.

REQ-008 On the first fault_any cycle while first_vld_o=0, the block SHALL register first_idx_o as the lowest set bit index of faulty_i and set first_vld_o=1; both then hold until clear.

REQ-009 irq_o SHALL rise in the cycle after the state register becomes PERMANENT, and stay high until a cycle with irq_ack_i=1, deasserting the following cycle.

REQ-010 irq_ack_i while irq_o=0 SHALL have no effect; an acknowledged irq SHALL NOT re-assert while the FSM remains in PERMANENT.

REQ-011 clear_i SHALL have priority over everything else: next cycle state=OK, persist_cnt=0, fault_cnt_o=0, first_vld_o=0, first_idx_o=0, irq_o=0, fault_mask_o=0. A fault_any in the same cycle as clear_i is discarded.

REQ-012 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Reset
REQ-013 Asserting rst_n low SHALL immediately force, independent of clk:
- state_o=0 and persist_cnt=0.
- fault_cnt_o=0.
- first_vld_o=0 and first_idx_o=0.
- irq_o=0 and fault_mask_o=0.

REQ-014 Reset asserted mid-TRANSIENT or mid-irq SHALL discard all history; after release, monitoring restarts from OK on the next rising edge.

REQ-015 Deassertion of rst_n is assumed synchronized externally; the block SHALL add no reset synchronizer.

Configuration
REQ-016 Macro CV32E40P_TMR_FAULT_MASK_EN SHALL control the sticky fault mask:
- Defined: each fault_mask_o bit SHALL be set on any cycle where en_i and the matching faulty_i bit are both 1, and held until clear_i or reset.
- Undefined: fault_mask_o SHALL be constant 0 and its register SHALL not be instantiated.

Verification
REQ-017 Directed scenarios, using defaults:
- Single faulty_i=32'h0000_0100 pulse for 1 cycle -> state 1 then 0; fault_cnt_o=1, first_idx_o=8, first_vld_o=1, irq_o stays 0.
- faulty_i=32'h0000_0006 held 4 cycles -> state 2 after the 4th edge, irq_o=1 one cycle later; fault_cnt_o=4, first_idx_o=1.
- irq_ack_i pulse while irq_o=1 and faults continue -> irq_o=0 next cycle and stays 0; state remains 2.
- clear_i in the same cycle as faulty_i=1 -> next cycle state=0, fault_cnt_o=0, first_vld_o=0.
- CNT_W=4 with faults held 20 cycles -> fault_cnt_o saturates at 15.
- rst_n low mid-TRANSIENT (cnt=2) -> outputs zero immediately; en_i=0 with faulty_i=all-ones -> no state change. With CV32E40P_TMR_FAULT_MASK_EN defined, faults on bits 3 and 7 -> fault_mask_o=32'h88.
